// File: rtl/mem_access_unit.sv
// Load/store unit between the core and a word-wide synchronous SRAM.
// Handles byte/half/word accesses, sign/zero extension, read-modify-write for partial stores, and fault detection.
module mem_access_unit #(
    parameter int A_BITS = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              err_misaligned,
    output logic              err_range,
    output logic [A_BITS-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t              state;
    state_t              state_next;
    logic                we_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic [A_BITS+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         data_q;
    logic [31:0]         merged;
    logic [31:0]         load_val;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic                misaligned;
    logic                out_of_range;
    logic                accept;

    // Faults are judged on the incoming request so a faulting access skips the SRAM entirely.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
        out_of_range = ((req_addr >> (A_BITS + 2)) != 32'd0);
        accept       = req_valid && (state == IDLE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned || out_of_range)
                        state_next = RESP;
                    else if (req_we && (req_size == 2'b10))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = WAIT;
            WAIT:    state_next = we_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_data_out[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = unsigned_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_data_out;
        endcase

        merged = data_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = data_q;
        endcase
    end

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign mem_read_en  = (state == READ);
    assign mem_write_en = (state == WRITE);
    assign mem_address  = addr_q[A_BITS+1:2];
    assign mem_data_in  = (size_q == 2'b10) ? wdata_q : merged;

    // Response fields are loaded on the way into RESP and then held until the next response.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= 32'd0;
            data_q         <= 32'd0;
            resp_rdata     <= 32'd0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr[A_BITS+1:0];
                wdata_q    <= req_wdata;
                if (misaligned || out_of_range) begin
                    resp_rdata     <= 32'd0;
                    err_misaligned <= misaligned;
                    err_range      <= !misaligned && out_of_range;
                end
            end
            if (state == WAIT) begin
                data_q <= mem_data_out;
                if (!we_q) begin
                    resp_rdata     <= load_val;
                    err_misaligned <= 1'b0;
                    err_range      <= 1'b0;
                end
            end
            if (state == WRITE) begin
                resp_rdata     <= 32'd0;
                err_misaligned <= 1'b0;
                err_range      <= 1'b0;
            end
        end
    end

endmodule
